// File: rtl/booth_radix4_multiplier.sv
// rtl/booth_radix4_multiplier.sv - sequential radix-4 Booth multiplier, one digit per clock
module booth_radix4_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int EXT   = WIDTH + 2;
    localparam int NITER = WIDTH / 2 + 1;
    localparam int HI    = WIDTH + 3;
    localparam int ACC   = HI + EXT;
    localparam int CW    = $clog2(NITER + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]      x_q;
    logic [WIDTH-1:0]      y_q;
    logic                  mode_q;
    logic [CW-1:0]         cnt;
    logic signed [ACC-1:0] acc;
    logic signed [ACC-1:0] acc_next;
    logic [EXT:0]          x_pad;
    logic [2:0]            trip;
    logic signed [HI-1:0]  y_hi;
    logic signed [HI-1:0]  pp;
    logic signed [HI-1:0]  upper_sum;
    logic                  last;

    // Extended X with the implicit zero below bit 0; digit i reads bits 2i+1..2i-1.
    assign x_pad = {{2{mode_q & x_q[WIDTH-1]}}, x_q, 1'b0};
    assign y_hi  = $signed({{3{mode_q & y_q[WIDTH-1]}}, y_q});
    assign trip  = x_pad[{cnt, 1'b0} +: 3];
    assign last  = (cnt == CW'(NITER - 1));

    always_comb begin
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = y_hi;
            3'b011:         pp = y_hi <<< 1;
            3'b100:         pp = -(y_hi <<< 1);
            3'b101, 3'b110: pp = -y_hi;
            default:        pp = '0;
        endcase
    end

    // Partial product lands in the upper part; the low EXT bits collect the shifted-out product.
    assign upper_sum = acc[ACC-1 -: HI] + pp;
    assign acc_next  = $signed({upper_sum, acc[EXT-1:0]}) >>> 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            Z      <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q    <= X;
                        y_q    <= Y;
                        mode_q <= signed_mode;
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        Z     <= acc_next[2*WIDTH-1:0];
                        valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb/tb_booth_radix4_multiplier.sv - randomized self-checking bench for booth_radix4_multiplier
module tb_booth_radix4_multiplier;

    logic clk = 1'b0;
    logic rst;
    logic sm;

    logic        start8, busy8, valid8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;

    logic        start4, busy4, valid4;
    logic [3:0]  x4, y4;
    logic [7:0]  z4;

    logic        start16, busy16, valid16;
    logic [15:0] x16, y16;
    logic [31:0] z16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm),
        .X(x8), .Y(y8), .busy(busy8), .valid(valid8), .Z(z8)
    );

    booth_radix4_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm),
        .X(x4), .Y(y4), .busy(busy4), .valid(valid4), .Z(z4)
    );

    booth_radix4_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm),
        .X(x16), .Y(y16), .busy(busy16), .valid(valid16), .Z(z16)
    );

    function automatic longint ref_prod(longint x, longint y, bit m, int w);
        longint xs = x;
        longint ys = y;
        longint one = 1;
        if (m && xs[w-1]) xs = xs - (one << w);
        if (m && ys[w-1]) ys = ys - (one << w);
        return (xs * ys) & ((one << (2 * w)) - 1);
    endfunction

    // Launches one WIDTH=8 operation and reports what was observed until valid.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic m,
                        output logic [15:0] z, output int kv, output int bcnt,
                        output int ovl, output int zmov);
        logic [15:0] z0;
        @(negedge clk);
        x8 = x; y8 = y; sm = m; start8 = 1'b1;
        z0 = z8;
        kv = 0; bcnt = 0; ovl = 0; zmov = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (busy8) bcnt++;
            if (busy8 && valid8) ovl++;
            if (valid8) begin
                kv = k;
                break;
            end
            if (z8 !== z0) zmov++;
        end
        z = z8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || z8 !== 16'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b z=%h required busy=0 valid=0 z=0000", busy8, valid8, z8);
        end
        rst = 1'b0;
    endtask

    task automatic test_corner_values();
        logic [15:0] z;
        int kv, bcnt, ovl, zmov;
        run8(8'h80, 8'h80, 1'b1, z, kv, bcnt, ovl, zmov);
        checks++;
        if (z !== 16'h4000) begin
            errors++;
            $display("FAIL min_times_min z=%h required 4000", z);
        end
        checks++;
        if (kv !== 6) begin
            errors++;
            $display("FAIL latency valid_cycle=%0d required 6", kv);
        end
        checks++;
        if (bcnt !== 5 || ovl !== 0) begin
            errors++;
            $display("FAIL busy_window busy_cycles=%0d overlap=%0d required 5 and 0", bcnt, ovl);
        end
        checks++;
        if (zmov !== 0) begin
            errors++;
            $display("FAIL z_hold z_changes_during_calc=%0d required 0", zmov);
        end
        run8(8'hFF, 8'hFF, 1'b0, z, kv, bcnt, ovl, zmov);
        checks++;
        if (z !== 16'hFE01) begin
            errors++;
            $display("FAIL unsigned_ff_ff z=%h required fe01", z);
        end
        checks++;
        if (zmov !== 0) begin
            errors++;
            $display("FAIL z_hold_2 z_changes_during_calc=%0d required 0", zmov);
        end
        run8(8'hFF, 8'hFF, 1'b1, z, kv, bcnt, ovl, zmov);
        checks++;
        if (z !== 16'h0001) begin
            errors++;
            $display("FAIL signed_ff_ff z=%h required 0001", z);
        end
    endtask

    task automatic test_input_isolation();
        int nval = 0;
        int vc = 0;
        logic [15:0] zr = 16'h0;
        @(negedge clk);
        x8 = 8'h03; y8 = 8'hF9; sm = 1'b1; start8 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (valid8) begin
                nval++;
                vc = c;
                zr = z8;
            end
            if (busy8) begin
                start8 = $urandom_range(0, 1);
                x8 = 8'($urandom);
                y8 = 8'($urandom);
                sm = 1'($urandom);
            end else begin
                start8 = 1'b0;
            end
        end
        checks++;
        if (zr !== 16'hFFEB) begin
            errors++;
            $display("FAIL isolation_result z=%h required ffeb", zr);
        end
        checks++;
        if (nval !== 1 || vc !== 6) begin
            errors++;
            $display("FAIL isolation_pulses count=%0d at_cycle=%0d required 1 at 6", nval, vc);
        end
    endtask

    task automatic test_back_to_back();
        int nval = 0;
        int bad_gap = 0;
        int bad_z = 0;
        longint exp_z;
        @(negedge clk);
        x8 = 8'hA7; y8 = 8'h5C; sm = 1'b1; start8 = 1'b1;
        exp_z = ref_prod(64'hA7, 64'h5C, 1'b1, 8);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (valid8) begin
                nval++;
                if (c % 6 != 0) bad_gap++;
                if (z8 !== 16'(exp_z)) bad_z++;
            end
        end
        start8 = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (nval !== 5 || bad_gap !== 0) begin
            errors++;
            $display("FAIL back_to_back_rate pulses=%0d off_grid=%0d required 5 and 0", nval, bad_gap);
        end
        checks++;
        if (bad_z !== 0) begin
            errors++;
            $display("FAIL back_to_back_z wrong_results=%0d required 0", bad_z);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] z;
        int kv, bcnt, ovl, zmov;
        @(negedge clk);
        x8 = 8'h35; y8 = 8'h92; sm = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || z8 !== 16'h0) begin
            errors++;
            $display("FAIL mid_calc_reset busy=%b valid=%b z=%h required 0 0 0000", busy8, valid8, z8);
        end
        run8(8'h9C, 8'h47, 1'b0, z, kv, bcnt, ovl, zmov);
        checks++;
        if (z !== 16'(ref_prod(64'h9C, 64'h47, 1'b0, 8)) || kv !== 6 || zmov !== 0) begin
            errors++;
            $display("FAIL after_reset_op z=%h cycle=%0d zmoves=%0d required %h at 6 with 0",
                     z, kv, zmov, 16'(ref_prod(64'h9C, 64'h47, 1'b0, 8)));
        end
    endtask

    task automatic test_random8();
        logic [15:0] z;
        int kv, bcnt, ovl, zmov;
        logic [7:0] a, b;
        logic m;
        int bad = 0;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            m = 1'(i % 2);
            run8(a, b, m, z, kv, bcnt, ovl, zmov);
            checks++;
            if (z !== 16'(ref_prod(64'(a), 64'(b), m, 8)) || kv !== 6) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random8 x=%h y=%h m=%b z=%h cycle=%0d required %h at 6",
                             a, b, m, z, kv, 16'(ref_prod(64'(a), 64'(b), m, 8)));
            end
        end
    endtask

    task automatic test_exhaustive4();
        int bad = 0;
        logic [7:0] exp_z;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    @(negedge clk);
                    x4 = 4'(a); y4 = 4'(b); sm = 1'(m); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    for (int k = 0; k < 10 && !valid4; k++) @(negedge clk);
                    exp_z = 8'(ref_prod(longint'(a), longint'(b), 1'(m), 4));
                    checks++;
                    if (valid4 !== 1'b1 || z4 !== exp_z) begin
                        errors++;
                        bad++;
                        if (bad < 5)
                            $display("FAIL exhaustive4 x=%h y=%h m=%0d valid=%b z=%h required %h",
                                     a, b, m, valid4, z4, exp_z);
                    end
                end
            end
        end
    endtask

    task automatic test_random16();
        int bad = 0;
        logic [31:0] exp_z;
        logic [15:0] a, b;
        for (int i = 0; i < 120; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) begin a = 16'h8000; b = 16'h8000; end
            if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
            @(negedge clk);
            x16 = a; y16 = b; sm = 1'(i % 2); start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            for (int k = 0; k < 20 && !valid16; k++) @(negedge clk);
            exp_z = 32'(ref_prod(64'(a), 64'(b), 1'(i % 2), 16));
            checks++;
            if (valid16 !== 1'b1 || z16 !== exp_z) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random16 x=%h y=%h m=%0d valid=%b z=%h required %h",
                             a, b, i % 2, valid16, z16, exp_z);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sm = 1'b0;
        start8 = 1'b0; x8 = '0; y8 = '0;
        start4 = 1'b0; x4 = '0; y4 = '0;
        start16 = 1'b0; x16 = '0; y16 = '0;
        test_reset();
        test_corner_values();
        test_input_isolation();
        test_back_to_back();
        test_reset_mid_calc();
        test_random8();
        test_exhaustive4();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_radix4_multiplier.md
BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits; even, >= 4.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: signed_mode  input  1  1 = X, Y two's complement; 0 = X, Y unsigned.
REQ-007 Port: X  input  WIDTH  multiplier operand.
REQ-008 Port: Y  input  WIDTH  multiplicand operand.
REQ-009 Port: busy  output  1  high while an operation is in CALC.
REQ-010 Port: valid  output  1  one-cycle completion strobe.
REQ-011 Port: Z  output  2*WIDTH  product, signed or unsigned per the captured mode.

Function
REQ-012 The state machine SHALL have two states, IDLE and CALC; IDLE SHALL be entered on reset.
REQ-013 IDLE with start=1 at a rising edge SHALL capture X, Y and signed_mode into internal registers, clear the accumulator and the digit counter, and enter CALC.
REQ-014 Operand and mode inputs SHALL be ignored after capture; changes during CALC SHALL not affect the result.
REQ-015 start SHALL be ignored while in CALC; no queuing, no restart.
REQ-016 Captured operands SHALL be extended to WIDTH+2 bits: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-017 The block SHALL use radix-4 Booth recoding of extended X with an implicit 0 below bit 0, giving NITER = WIDTH/2+1 digits in {-2,-1,0,+1,+2}.
REQ-018 Recoding SHALL use triplet 000/111 -> 0, 001/010 -> +Y, 011 -> +2Y, 100 -> -2Y, 101/110 -> -Y.
REQ-019 One digit SHALL be processed per clock in CALC: add the digit times extended Y into the accumulator upper part, then arithmetic-shift right by 2.
REQ-020 The accumulator SHALL be at least WIDTH+3 bits wide in its upper part, so that ±2Y never overflows.
REQ-021 CALC SHALL last exactly NITER cycles, independent of operand values and mode.
REQ-022 On the edge that completes digit NITER, the block SHALL:
- load Z with the low 2*WIDTH bits of the exact product;
- assert valid for exactly one cycle;
- deassert busy;
- return to IDLE.
REQ-023 Latency: start sampled at edge E0 -> valid=1 and Z updated during the cycle after edge E0+NITER (5 cycles for WIDTH=8).
REQ-024 busy SHALL be 1 from the cycle after E0 until valid is asserted; busy and valid SHALL never be high together.
REQ-025 Z SHALL hold its value in all cycles except the completion edge, including through later CALC periods.
REQ-026 start=1 in the cycle where valid=1 (state IDLE) SHALL be accepted, giving back-to-back operations every NITER+1 cycles.
REQ-027 The result SHALL be exact for all operand pairs, including the most-negative signed value times itself and the all-ones unsigned value times itself.

Reset
REQ-028 rst=1 at a rising edge SHALL force: state IDLE, Z=0, valid=0, busy=0, accumulator, counter and captured registers to 0.
REQ-029 rst SHALL take priority over start and over any CALC step.
REQ-030 Reset mid-CALC SHALL abort the operation; no valid pulse SHALL follow, and Z SHALL read 0.
REQ-031 After reset release the block SHALL accept start on the first edge with rst=0.

Verification
REQ-032 WIDTH=8, signed_mode=1, X=0x80 (-128), Y=0x80 -> valid after 5 cycles, Z=0x4000; busy high exactly 5 cycles.
REQ-033 WIDTH=8, signed_mode=0, X=0xFF, Y=0xFF -> Z=0xFE01; signed_mode=1 with the same operands -> Z=0x0001.
REQ-034 WIDTH=8, signed X=0x03 (3), Y=0xF9 (-7) -> Z=0xFFEB (-21); during CALC, X, Y and start toggled each cycle -> result unchanged, exactly one valid pulse.
REQ-035 Back-to-back: start held high continuously with fixed operands -> valid every 6 cycles, Z correct each time.
REQ-036 rst pulsed in the 3rd CALC cycle -> busy=0, Z=0, no valid; a new start 1 cycle later completes correctly.
REQ-037 Randomised sweep, WIDTH in {4, 8, 16}, both modes, against a reference model -> all products match; exhaustive for WIDTH=4.
